// File: rtl/cache_fill_fsm_pkg.sv
// cache_pkg: fill-state encoding and line-geometry constants shared by the cache fill FSM.
package cache_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} fill_state_t;
    localparam int WPL_DEFAULT = 8;
    localparam int WORD_BYTES  = 2;
    function automatic int word_bits(input int words);
        return $clog2(words);
    endfunction
    // Byte-offset bits inside one line: word index plus the byte-in-word bit.
    function automatic int line_offset_bits(input int words);
        return $clog2(words) + $clog2(WORD_BYTES);
    endfunction
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss request, memory read channel and data/tag array write strobes.
// master = fill FSM, slave = cache/memory side.
interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORDS_PER_LINE = 8
);
    localparam int WW = $clog2(WORDS_PER_LINE);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic [15:0]           memory_data;
    logic                  memory_data_valid;
    logic                  mem_enable;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  fsm_busy;
    logic                  write_data_array;
    logic [WW-1:0]         data_word_index;
    logic                  write_tag_array;
    // memory_data flows straight to the data array; the FSM only sees its valid strobe.
    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output mem_enable, memory_address, fsm_busy, write_data_array, data_word_index, write_tag_array
    );
    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  mem_enable, memory_address, fsm_busy, write_data_array, data_word_index, write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: modulo-N word counter with load/enable; o_done flags that the next step is the Nth.
module fill_counter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_cnt,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_num;
    // N is a power of two, so natural W-bit overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_num <= '0;
        end else if (i_load) begin
            r_cnt <= i_start;
            r_num <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
            r_num <= r_num + W'(1);
        end
    end
    assign o_cnt  = r_cnt;
    assign o_done = r_num == W'(N - 1);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one cache line word-by-word after a miss and strobes data/tag writes.
// FILL_CRITICAL_WORD_FIRST_EN: start the fill at the missing word and wrap around the line.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORDS_PER_LINE = WPL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    cache_fill_fsm_if.master bus
);
    localparam int WW = word_bits(WORDS_PER_LINE);
    localparam int OW = line_offset_bits(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OW) - 1);
    fill_state_t           r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic [WW-1:0]         w_start, w_issue_cnt, w_ret_cnt;
    logic                  w_issue_last, w_ret_last, w_load, w_ret, w_busy;
    assign w_busy = r_state != S_IDLE;
    assign w_load = !w_busy && bus.miss_detected;
    assign w_ret  = w_busy && bus.memory_data_valid;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign w_start = bus.miss_address[OW-1:1];
`else
    assign w_start = '0;
`endif
    fill_counter #(.N(WORDS_PER_LINE), .W(WW)) u_issue (
        .clk(clk), .rst(rst), .i_load(w_load), .i_en(r_state == S_ISSUE),
        .i_start(w_start), .o_cnt(w_issue_cnt), .o_done(w_issue_last)
    );
    fill_counter #(.N(WORDS_PER_LINE), .W(WW)) u_ret (
        .clk(clk), .rst(rst), .i_load(w_load), .i_en(w_ret),
        .i_start(w_start), .o_cnt(w_ret_cnt), .o_done(w_ret_last)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_line_base <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) r_line_base <= bus.miss_address & LINE_MASK;
        end
    end
    // The final return wins over the issue->wait step so zero-latency fills end without a 9th request.
    always_comb begin
        w_next = r_state;
        if (!w_busy) w_next = w_load ? S_ISSUE : S_IDLE;
        else if (w_ret && w_ret_last) w_next = S_IDLE;
        else if (r_state == S_ISSUE && w_issue_last) w_next = S_WAIT;
    end
    always_comb begin
        bus.mem_enable       = r_state == S_ISSUE;
        bus.memory_address   = (r_state == S_ISSUE) ? (r_line_base | ADDR_WIDTH'({w_issue_cnt, 1'b0})) : '0;
        bus.fsm_busy         = w_busy;
        bus.write_data_array = w_ret;
        bus.data_word_index  = w_busy ? w_ret_cnt : '0;
        bus.write_tag_array  = w_ret && w_ret_last;
    end
endmodule
